// File: rtl/pipeline_trace_buffer.sv
// Circular trace buffer for pipeline-register taps. It captures until a programmable
// number of samples after a halt/trigger, then serves the history oldest-first.
module pipeline_trace_buffer #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 5,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int SW    = NUM_CH * DATA_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arm,
  input  logic          sample_valid,
  input  logic [SW-1:0] sample_data,
  input  logic          stall,
  input  logic          halt,
  input  logic          trig_ext,
  input  logic [AW:0]   post_count,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [SW-1:0] rd_data,
  output logic [1:0]    state,
  output logic          done,
  output logic [AW:0]   sample_count,
  output logic [AW-1:0] trig_pos,
  output logic [15:0]   stall_cycles
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] MAX_POST = AW'(DEPTH - 1);

  logic [SW-1:0] r_mem [DEPTH];

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_wptr, w_wptr_nxt;
  logic [AW:0]   r_count, w_count_nxt;
  logic [AW-1:0] r_remain, w_remain_nxt;
  logic [AW-1:0] r_post, w_post_nxt;
  logic [AW-1:0] r_trig_pos, w_trig_pos_nxt;
  logic [15:0]   r_stall, w_stall_nxt;
  logic          r_done;

  logic          w_capt, w_wr, w_trig;
  logic [AW:0]   w_cnt_inc, w_tp_calc;
  logic [AW-1:0] w_clamp, w_oldest, w_rd_idx;
  logic          w_rd_in;

  logic          r_rd_vld_p1;
  logic [SW-1:0] r_rd_data_p1;

  assign w_capt    = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_wr      = sample_valid & w_capt & ~arm;
  assign w_trig    = sample_valid & (halt | trig_ext) & (r_state == S_ARMED) & ~arm;
  assign w_cnt_inc = (r_count == FULL) ? r_count : r_count + 1'b1;
  assign w_clamp   = (post_count > {1'b0, MAX_POST}) ? MAX_POST : post_count[AW-1:0];

  always_comb begin
    w_state_nxt    = r_state;
    w_wptr_nxt     = r_wptr;
    w_count_nxt    = r_count;
    w_remain_nxt   = r_remain;
    w_post_nxt     = r_post;
    w_trig_pos_nxt = r_trig_pos;
    w_stall_nxt    = r_stall;
    w_tp_calc      = '0;
    if (arm) begin
      w_state_nxt    = S_ARMED;
      w_wptr_nxt     = '0;
      w_count_nxt    = '0;
      w_remain_nxt   = '0;
      w_post_nxt     = '0;
      w_trig_pos_nxt = '0;
      w_stall_nxt    = '0;
    end else begin
      if (w_capt && stall && (r_stall != 16'hFFFF))
        w_stall_nxt = r_stall + 16'd1;
      if (w_wr) begin
        w_wptr_nxt  = r_wptr + 1'b1;
        w_count_nxt = w_cnt_inc;
      end
      case (r_state)
        S_ARMED: begin
          if (w_trig) begin
            w_post_nxt = w_clamp;
            if (w_clamp == '0) begin
              w_state_nxt    = S_DONE;
              w_tp_calc      = w_cnt_inc - 1'b1;
              w_trig_pos_nxt = w_tp_calc[AW-1:0];
            end else begin
              w_state_nxt  = S_POST;
              w_remain_nxt = w_clamp;
            end
          end
        end
        S_POST: begin
          if (w_wr) begin
            w_remain_nxt = r_remain - 1'b1;
            if (r_remain == AW'(1)) begin
              w_state_nxt    = S_DONE;
              w_tp_calc      = w_cnt_inc - 1'b1 - {1'b0, r_post};
              w_trig_pos_nxt = w_tp_calc[AW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_count    <= '0;
      r_remain   <= '0;
      r_post     <= '0;
      r_trig_pos <= '0;
      r_stall    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wptr     <= w_wptr_nxt;
      r_count    <= w_count_nxt;
      r_remain   <= w_remain_nxt;
      r_post     <= w_post_nxt;
      r_trig_pos <= w_trig_pos_nxt;
      r_stall    <= w_stall_nxt;
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= sample_data;
  end

  // Read stage: index 0 is the oldest entry, which is wptr once the buffer has wrapped
  assign w_oldest = (r_count == FULL) ? r_wptr : '0;
  assign w_rd_idx = w_oldest + rd_addr;
  assign w_rd_in  = ({1'b0, rd_addr} < r_count);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_vld_p1  <= 1'b0;
      r_rd_data_p1 <= '0;
    end else if (rd_req && (r_state == S_DONE)) begin
      r_rd_vld_p1  <= 1'b1;
      r_rd_data_p1 <= w_rd_in ? r_mem[w_rd_idx] : '0;
    end else begin
      r_rd_vld_p1  <= 1'b0;
    end
  end

  assign rd_valid     = r_rd_vld_p1;
  assign rd_data      = r_rd_data_p1;
  assign state        = r_state;
  assign done         = r_done;
  assign sample_count = r_count;
  assign trig_pos     = r_trig_pos;
  assign stall_cycles = r_stall;

endmodule
